mbs_arbiter: RTL and testbench

Shares one 8-bit sequential shift-add multiplier core between two requesters. Round-robin arbitration picks a requester, which receives a one-cycle grant. The block then steps the core one partial product per clock and returns the 16-bit product with a one-cycle done pulse. It sits between the two multiply clients and the `mbs_core` datapath and owns all sequencing of that datapath.

---
 rtl/mbs_pkg.sv | 17 +
 rtl/mbs_core.sv | 51 +++++
 rtl/mbs_arbiter.sv | 129 ++++++++++++
 tb/tb_mbs_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mbs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mbs_pkg : shared types and constants for the shared multiplier block |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mbs_pkg;

   localparam int MBS_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mbs_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mbs_core : shift-add multiplier datapath, one partial product/cycle  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mbs_core
   import mbs_pkg::*;
#(
   parameter int WIDTH = MBS_WIDTH
) (
   input  logic                 Clock,
   input  logic                 Load,
   input  logic                 Step,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic [2*WIDTH-1:0]   Acc
);

   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] mcand_q,  mcand_d;
   logic [2*WIDTH-1:0] acc_q,    acc_d;

   always_comb begin
      mplier_d = mplier_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      if (Load) begin
         mplier_d = A;
         mcand_d  = {{WIDTH{1'b0}}, B};
         acc_d    = '0;
      end else if (Step) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
      end
   end

   always_ff @(posedge Clock) begin
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
   end

   // Accumulator including this cycle's step, so the final product can be
   // registered by the controller on the same edge as the last step.
   assign Acc = acc_d;

endmodule
`default_nettype wire

// File: rtl/mbs_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mbs_arbiter : round-robin sharing of one mbs_core between two users  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mbs_arbiter
   import mbs_pkg::*;
#(
   parameter int WIDTH = MBS_WIDTH
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Req0,
   input  logic                 Req1,
   input  logic [WIDTH-1:0]     A0,
   input  logic [WIDTH-1:0]     B0,
   input  logic [WIDTH-1:0]     A1,
   input  logic [WIDTH-1:0]     B1,
   output logic                 Gnt0,
   output logic                 Gnt1,
   output logic                 Done0,
   output logic                 Done1,
   output logic [2*WIDTH-1:0]   P,
   output logic                 Busy
);

   localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               last_q, last_d;
   logic               owner_q, owner_d;
   logic [2*WIDTH-1:0] p_q, p_d;
   logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic               done0_q, done0_d, done1_q, done1_d;
   logic               busy_q;
   logic               load, step, win1;
   logic [WIDTH-1:0]   core_a, core_b;
   logic [2*WIDTH-1:0] acc;

   // Requester 1 wins when alone, or on a tie when requester 0 was served last.
   assign win1   = Req1 & (~Req0 | ~last_q);
   assign core_a = win1 ? A1 : A0;
   assign core_b = win1 ? B1 : B0;

   mbs_core #(.WIDTH(WIDTH)) u_core (
      .Clock (Clock),
      .Load  (load),
      .Step  (step),
      .A     (core_a),
      .B     (core_b),
      .Acc   (acc)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      owner_d = owner_q;
      p_d     = p_q;
      load    = 1'b0;
      step    = 1'b0;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (Req0 | Req1) begin
               state_d = RUN;
               load    = 1'b1;
               cnt_d   = '0;
               last_d  = win1;
               owner_d = win1;
               gnt0_d  = ~win1;
               gnt1_d  = win1;
            end
         end
         RUN: begin
            step  = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               p_d     = acc;
               done0_d = ~owner_q;
               done1_d = owner_q;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         p_q     <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         p_q     <= p_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   assign Gnt0  = gnt0_q;
   assign Gnt1  = gnt1_q;
   assign Done0 = done0_q;
   assign Done1 = done1_q;
   assign P     = p_q;
   assign Busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mbs_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mbs_arbiter : scoreboard bench with a behavioural arbiter model   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mbs_arbiter;

   localparam int W = 8;

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic          Req0 = 1'b0, Req1 = 1'b0;
   logic [W-1:0]  A0 = '0, B0 = '0, A1 = '0, B1 = '0;
   logic          Gnt0, Gnt1, Done0, Done1, Busy;
   logic [2*W-1:0] P;

   mbs_arbiter #(.WIDTH(W)) dut (
      .Clock (Clock), .Reset (Reset),
      .Req0  (Req0),  .Req1  (Req1),
      .A0    (A0),    .B0    (B0),
      .A1    (A1),    .B1    (B1),
      .Gnt0  (Gnt0),  .Gnt1  (Gnt1),
      .Done0 (Done0), .Done1 (Done1),
      .P     (P),     .Busy  (Busy)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      int            cyc;
      bit            done;
      bit            id;
      logic [2*W-1:0] prod;
   } ev_t;

   ev_t            sb[$];
   int             total = 0;
   int             bad   = 0;
   int             cyc   = 0;
   bit             chk_en = 1'b0;
   bit             rnd_en = 1'b0;

   // Model: remaining busy cycles, last served requester, expected outputs.
   int             rem = 0;
   bit             last = 1'b1;
   bit             exp_busy = 1'b0;
   logic [2*W-1:0] exp_p = '0;
   int             pend_cyc = -1;
   logic [2*W-1:0] pend_prod = '0;
   bit             captured = 1'b0;
   int             drop_at[2] = '{-1, -1};
   bit             hold[2] = '{1'b0, 1'b0};

   task automatic check_pulse(input logic v, input bit d, input bit id);
      ev_t ev;
      if (v !== 1'b0) begin
         total++;
         if (v === 1'b1 && sb.size() > 0 && sb[0].cyc == cyc &&
             sb[0].done == d && sb[0].id == id) begin
            ev = sb.pop_front();
            if (d) begin
               total++;
               if (P !== ev.prod) begin
                  bad++;
                  $display("FAIL done_product id=%0d cyc=%0d got=%h want=%h", id, cyc, P, ev.prod);
               end
            end
         end else begin
            bad++;
            $display("FAIL unexpected_pulse done=%0d id=%0d cyc=%0d got=%b want=0", d, id, cyc, v);
         end
      end
   endtask

   always @(negedge Clock) begin
      if (chk_en) begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_pulse done=%0d id=%0d cyc=%0d got=0 want=1",
                     sb[0].done, sb[0].id, sb[0].cyc);
            void'(sb.pop_front());
         end
         total++;
         if (Busy !== exp_busy) begin
            bad++;
            $display("FAIL busy cyc=%0d got=%b want=%b", cyc, Busy, exp_busy);
         end
         total++;
         if (P !== exp_p) begin
            bad++;
            $display("FAIL p_hold cyc=%0d got=%h want=%h", cyc, P, exp_p);
         end
         check_pulse(Gnt0, 1'b0, 1'b0);
         check_pulse(Gnt1, 1'b0, 1'b1);
         check_pulse(Done0, 1'b1, 1'b0);
         check_pulse(Done1, 1'b1, 1'b1);
      end
   end

   task automatic raise(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      if (i == 0) begin Req0 = 1'b1; A0 = a; B0 = b; end
      else        begin Req1 = 1'b1; A1 = a; B1 = b; end
      drop_at[i] = -1;
   endtask

   task automatic start_cycle();
      exp_busy = (rem > 0);
      if (pend_cyc == cyc) exp_p = pend_prod;
      if (drop_at[0] == cyc) Req0 = 1'b0;
      if (drop_at[1] == cyc) Req1 = 1'b0;
      if (rnd_en) begin
         if (!Req0 && drop_at[0] != cyc && $urandom_range(0, 5) == 0)
            raise(0, W'($urandom), W'($urandom));
         if (!Req1 && drop_at[1] != cyc && $urandom_range(0, 5) == 0)
            raise(1, W'($urandom), W'($urandom));
      end
   endtask

   // Decision for the current cycle, evaluated after the monitor has sampled it.
   task automatic end_cycle();
      bit             w;
      logic [2*W-1:0] prod;
      captured = 1'b0;
      if (Reset) begin
         rem      = 0;
         last     = 1'b1;
         pend_cyc = -1;
         exp_p    = '0;
         while (sb.size() > 0 && sb[sb.size()-1].cyc > cyc) void'(sb.pop_back());
      end else if (rem == 0 && (Req0 || Req1)) begin
         w    = (Req0 && Req1) ? !last : Req1;
         last = w;
         prod = w ? ({{W{1'b0}}, A1} * {{W{1'b0}}, B1}) : ({{W{1'b0}}, A0} * {{W{1'b0}}, B0});
         sb.push_back('{cyc + 1,     1'b0, w, '0});
         sb.push_back('{cyc + W + 1, 1'b1, w, prod});
         pend_cyc  = cyc + W + 1;
         pend_prod = prod;
         rem       = W + 1;
         captured  = 1'b1;
         if (!hold[w]) drop_at[w] = cyc + 2;
      end else if (rem > 0) begin
         rem--;
      end
   endtask

   task automatic step();
      @(negedge Clock);
      #1;
      end_cycle();
      @(posedge Clock);
      #1;
      cyc++;
      start_cycle();
   endtask

   task automatic run_until_idle();
      int n = 0;
      while ((rem != 0 || Req0 || Req1) && n < 300) begin
         step();
         n++;
      end
      if (n >= 300) begin
         total++;
         bad++;
         $display("FAIL idle_timeout cyc=%0d got=busy want=idle", cyc);
      end
   endtask

   initial begin
      step();
      chk_en = 1'b1;
      step();
      step();
      Reset = 1'b0;
      step();

      raise(0, 8'd13, 8'd11);
      run_until_idle();
      raise(1, 8'd255, 8'd255);
      run_until_idle();
      raise(0, 8'd0, 8'd200);
      run_until_idle();

      // Ties straight after reset: requester 0 first, then 1, then 0 again.
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      raise(0, 8'd3, 8'd5);
      raise(1, 8'd7, 8'd9);
      run_until_idle();
      raise(0, 8'd21, 8'd4);
      raise(1, 8'd6, 8'd17);
      run_until_idle();

      // Both requesters holding their requests: grants must alternate.
      hold[0] = 1'b1;
      hold[1] = 1'b1;
      raise(0, 8'd200, 8'd3);
      raise(1, 8'd99, 8'd77);
      repeat (45) step();
      hold[0] = 1'b0;
      hold[1] = 1'b0;
      run_until_idle();

      // Reset during the 4th RUN cycle, then a fresh request.
      raise(0, 8'd123, 8'd45);
      begin
         int n = 0;
         do begin step(); n++; end while (!captured && n < 50);
      end
      repeat (3) step();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      step();
      raise(1, 8'd9, 8'd7);
      run_until_idle();

      // Requester 1 arrives mid-RUN and must wait for IDLE.
      raise(0, 8'd100, 8'd50);
      repeat (3) step();
      raise(1, 8'd20, 8'd30);
      run_until_idle();

      rnd_en = 1'b1;
      repeat (600) step();
      rnd_en = 1'b0;
      run_until_idle();
      repeat (3) step();

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL leftover_events got=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
